led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Sequencer for the board LED. It schedules a PWM duty-cycle pattern (off, steady on, blink, breathe) from a prescaled tick, and drives the LED through an internal PWM comparator. Duty changes are applied only at PWM period boundaries, so the output never glitches. It replaces the fixed-toggle LED control in the top level: the top instantiates this block and feeds it mode writes from switches or a bus.

Parameters:
PRESCALE, 11, clk cycles per pattern tick (>=2)
PWM_BITS, 8, PWM resolution; MAX = 2^PWM_BITS-1 = PWM period in clk cycles
STEP, 4, duty increment/decrement per tick in breathe mode (1..MAX)
BLINK_TICKS, 64, ticks per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
mode_i  in  2  requested mode: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE
mode_we  in  1  one-cycle strobe; captures mode_i
led  out  1  PWM LED drive
duty  out  PWM_BITS  currently applied duty
cycle_done  out  1  one-cycle pulse at the end of each blink or breathe cycle

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset: mode=OFF, state=S_OFF, all counters 0, duty_target=0, duty=0, led=0, cycle_done=0. Asserting rst mid-pattern clears everything at the next edge.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick=1 for the one cycle where pre_cnt==PRESCALE-1.
- PWM: pwm_cnt counts 0..MAX-1 and wraps.
  - led = (pwm_cnt < duty), combinational from registers.
  - duty <= duty_target only on the cycle pwm_cnt==MAX-1, so the new value takes effect at pwm_cnt=0.
  - duty=0 gives led constant 0. duty=MAX gives led constant 1.
- Mode write: when mode_we=1, the next edge captures mode_i, clears pre_cnt and blink_cnt, and enters the mode's start state.
  - A write during the same cycle as a tick discards that tick.
  - Writing the current mode restarts the pattern.
  - pwm_cnt is never cleared by a mode write.
- FSM states and transitions:
  - S_OFF: duty_target=0. No tick action.
  - S_ON: duty_target=MAX. No tick action.
  - S_BLINK_H: entry sets duty_target=MAX. Each tick increments blink_cnt. When blink_cnt reaches BLINK_TICKS, clear blink_cnt and go to S_BLINK_L.
  - S_BLINK_L: entry sets duty_target=0. Same counting. When blink_cnt reaches BLINK_TICKS, go to S_BLINK_H and pulse cycle_done.
  - S_UP (breathe start, duty_target=0 on entry): on tick, if duty_target+STEP >= MAX then set duty_target=MAX and go to S_DOWN; else add STEP.
  - S_DOWN: on tick, if duty_target <= STEP then set duty_target=0, go to S_UP and pulse cycle_done; else subtract STEP.
- Arithmetic: breathe add/compare uses PWM_BITS+1 bits. duty_target never wraps; it saturates at 0 and MAX.
- cycle_done is registered, high exactly one clk, and is 0 in OFF and ON modes.

Decomposition:
- Package led_ctrl_pkg:
  - mode encodings MODE_OFF/ON/BLINK/BREATHE
  - state enum S_OFF, S_ON, S_BLINK_H, S_BLINK_L, S_UP, S_DOWN
  - width helper for counters
- Sub-module tick_gen(PRESCALE):
  - inputs clk, rst, clr
  - output tick
  - holds the prescaler
- FSM, duty registers and PWM stay in the top of this block.

Test Plan (PRESCALE=4, PWM_BITS=3 so MAX=7, STEP=2, BLINK_TICKS=3):
- rst high 2 cycles, then low with no writes for 50 cycles -> led=0, duty=0, cycle_done=0 throughout.
- mode_we with mode_i=1 -> duty becomes 7 within 7 clk, at a pwm_cnt wrap; led then stays constant 1.
- mode_we with mode_i=3 -> duty_target sequence 0,2,4,6,7,5,3,1,0 changing every 4 clk; cycle_done pulses once at the return to 0; duty changes only at pwm_cnt=0.
- mode_we with mode_i=2 -> duty_target 7 for 12 clk, then 0 for 12 clk, repeating; cycle_done pulses at each end of the low phase.
- Breathe with duty_target=4, then write mode 0 on the same cycle as a tick -> duty_target=0 next cycle, not 6; led 0 from the next PWM period. Separately, assert rst mid-blink -> all outputs 0 after one edge.
- Hold duty_target=3 (ON, then BREATHE, stopped via mode writes) -> led high exactly 3 of every 7 consecutive clk.

Source files
------------

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types for the LED pattern sequencer.
// Mode encodings, FSM states and small helpers.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_ON,
        S_BLINK_H,
        S_BLINK_L,
        S_UP,
        S_DOWN
    } state_e;

    // Bits needed for a counter running 0..n-1
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic state_e start_state(input mode_e m);
        state_e s;
        unique case (m)
            MODE_OFF:     s = S_OFF;
            MODE_ON:      s = S_ON;
            MODE_BLINK:   s = S_BLINK_H;
            MODE_BREATHE: s = S_UP;
            default:      s = S_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Mode-write and LED-status bundle for led_pattern_ctrl.
// master: mode_i/mode_we out, led/duty/cycle_done in; slave: reverse.
interface led_pattern_ctrl_if #(
    parameter int PWM_BITS = 8
) ();
    logic [1:0]          mode_i;
    logic                mode_we;
    logic                led;
    logic [PWM_BITS-1:0] duty;
    logic                cycle_done;

    modport master (
        output mode_i, mode_we,
        input  led, duty, cycle_done
    );

    modport slave (
        input  mode_i, mode_we,
        output led, duty, cycle_done
    );
endinterface

// File: rtl/led_pattern_ctrl_tick.sv
// Pattern-tick prescaler: one-cycle tick every PRESCALE clocks.
// Ports: clk, rst (sync, high), clr (restart count), tick (out).
module tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int PRESCALE = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = cnt_w(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] pre_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre_cnt <= '0;
        end else if (pre_cnt == LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + W'(1);
        end
    end

    assign tick = (pre_cnt == LAST);
endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: OFF/ON/BLINK/BREATHE duty schedule + PWM.
// Ports: clk, rst (sync, high), bus (slave: mode_i, mode_we, led, duty, cycle_done).
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int PRESCALE    = 11,
    parameter int PWM_BITS    = 8,
    parameter int STEP        = 4,
    parameter int BLINK_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    led_pattern_ctrl_if.slave bus
);
    localparam int MAX = 2**PWM_BITS - 1;
    localparam int BW  = cnt_w(BLINK_TICKS);

    localparam logic [PWM_BITS-1:0] DMAX     = PWM_BITS'(MAX);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX - 1);
    localparam logic [PWM_BITS-1:0] STEP_D   = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   MAX_X    = (PWM_BITS+1)'(MAX);
    localparam logic [PWM_BITS:0]   STEP_X   = (PWM_BITS+1)'(STEP);
    localparam logic [BW-1:0]       BT_LAST  = BW'(BLINK_TICKS - 1);

    state_e              state, state_nx;
    logic [PWM_BITS-1:0] dt, dt_nx;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BW-1:0]       blink_cnt, blink_nx;
    logic                cd_q, cd_nx;
    logic [PWM_BITS:0]   up_sum;
    logic                tick;

    // A mode write restarts the prescaler so the first tick of a
    // new pattern is a full PRESCALE after the write.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.mode_we),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        dt_nx    = dt;
        blink_nx = blink_cnt;
        cd_nx    = 1'b0;
        // One extra bit so dt+STEP cannot wrap before the compare
        up_sum   = {1'b0, dt} + STEP_X;

        // A write outranks a coincident tick: that tick is dropped.
        if (bus.mode_we) begin
            state_nx = start_state(mode_e'(bus.mode_i));
            blink_nx = '0;
            if (state_nx == S_ON || state_nx == S_BLINK_H) begin
                dt_nx = DMAX;
            end else begin
                dt_nx = '0;
            end
        end else begin
            unique case (state)
                S_OFF: dt_nx = '0;
                S_ON:  dt_nx = DMAX;
                S_BLINK_H, S_BLINK_L: begin
                    if (tick) begin
                        if (blink_cnt == BT_LAST) begin
                            blink_nx = '0;
                            if (state == S_BLINK_H) begin
                                state_nx = S_BLINK_L;
                                dt_nx    = '0;
                            end else begin
                                state_nx = S_BLINK_H;
                                dt_nx    = DMAX;
                                cd_nx    = 1'b1;
                            end
                        end else begin
                            blink_nx = blink_cnt + BW'(1);
                        end
                    end
                end
                S_UP: begin
                    if (tick) begin
                        if (up_sum >= MAX_X) begin
                            dt_nx    = DMAX;
                            state_nx = S_DOWN;
                        end else begin
                            dt_nx = up_sum[PWM_BITS-1:0];
                        end
                    end
                end
                S_DOWN: begin
                    if (tick) begin
                        if ({1'b0, dt} <= STEP_X) begin
                            dt_nx    = '0;
                            state_nx = S_UP;
                            cd_nx    = 1'b1;
                        end else begin
                            dt_nx = dt - STEP_D;
                        end
                    end
                end
                default: state_nx = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OFF;
            dt        <= '0;
            blink_cnt <= '0;
            cd_q      <= 1'b0;
            pwm_cnt   <= '0;
            duty_q    <= '0;
        end else begin
            state     <= state_nx;
            dt        <= dt_nx;
            blink_cnt <= blink_nx;
            cd_q      <= cd_nx;
            // Duty is latched on the last count of the period so the
            // new value starts cleanly at pwm_cnt == 0.
            if (pwm_cnt == PWM_LAST) begin
                pwm_cnt <= '0;
                duty_q  <= dt;
            end else begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    assign bus.led        = (pwm_cnt < duty_q);
    assign bus.duty       = duty_q;
    assign bus.cycle_done = cd_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl (PRESCALE=4, MAX=7, STEP=2, BLINK_TICKS=3).
// Expected per-edge outputs are queued with stimulus; a negedge monitor compares.
module tb_led_pattern_ctrl;

    typedef struct {
        int         cyc;
        logic [2:0] duty;
        logic       led;
        logic       cd;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];
    exp_t e;

    led_pattern_ctrl_if #(.PWM_BITS(3)) bus ();

    led_pattern_ctrl #(
        .PRESCALE    (4),
        .PWM_BITS    (3),
        .STEP        (2),
        .BLINK_TICKS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edges where cycle_done must be high (end of breathe, ends of blink low)
    function automatic logic is_cd(input int n);
        return (n == 97) || (n == 132) || (n == 156);
    endfunction

    // Expect duty d on edges a..b; pwm_cnt is 0 after edge org (last reset)
    task automatic push_seg(input string nm, input int a, input int b,
                            input int d, input int org);
        exp_t r;
        int   p;
        for (int n = a; n <= b; n++) begin
            p      = (n >= org) ? (n - org) % 7 : 0;
            r.cyc  = n;
            r.duty = 3'(d);
            r.led  = (p < d);
            r.cd   = is_cd(n);
            r.name = $sformatf("%s@%0d", nm, n);
            q.push_back(r);
        end
    endtask

    task automatic write_at(input int n, input logic [1:0] m);
        while (cyc < n - 1) @(negedge clk);
        bus.mode_i  = m;
        bus.mode_we = 1'b1;
        @(negedge clk);
        bus.mode_we = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: not sampled (now edge %0d)", e.name, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if (bus.duty !== e.duty || bus.led !== e.led ||
                bus.cycle_done !== e.cd) begin
                errors++;
                $display("FAIL %s: got duty=%0d led=%0b cd=%0b, want duty=%0d led=%0b cd=%0b",
                         e.name, bus.duty, bus.led, bus.cycle_done,
                         e.duty, e.led, e.cd);
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.mode_i  = 2'd0;
        bus.mode_we = 1'b0;

        // Reset for edges 1-2, then idle through edge 52
        push_seg("reset_idle", 1, 52, 0, 2);
        while (cyc < 2) @(negedge clk);
        rst = 1'b0;

        // ON: duty reaches 7 at the wrap on edge 58
        push_seg("on_wait", 53, 57, 0, 2);
        push_seg("on_full", 58, 64, 7, 2);
        write_at(53, 2'd1);

        // BREATHE from edge 65: target 0,2,4,6,7,5,3,1,0 every 4 clk
        push_seg("br_7", 65, 71, 7, 2);
        push_seg("br_2", 72, 78, 2, 2);
        push_seg("br_6", 79, 85, 6, 2);
        push_seg("br_5", 86, 92, 5, 2);
        push_seg("br_3", 93, 99, 3, 2);
        push_seg("br_0", 100, 106, 0, 2);
        push_seg("br_4", 107, 107, 4, 2);
        write_at(65, 2'd3);

        // BLINK from edge 108: 12 clk high, 12 clk low
        push_seg("bl_4", 108, 113, 4, 2);
        push_seg("bl_h1", 114, 120, 7, 2);
        push_seg("bl_l1", 121, 134, 0, 2);
        push_seg("bl_h2", 135, 148, 7, 2);
        push_seg("bl_l2", 149, 162, 0, 2);
        write_at(108, 2'd2);

        // Reset mid-blink on edge 163
        push_seg("mid_rst", 163, 169, 0, 163);
        while (cyc < 162) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // BREATHE again, then OFF on the tick edge 182 (target would be 6)
        push_seg("br2_0", 170, 176, 0, 163);
        push_seg("br2_2", 177, 183, 2, 163);
        write_at(170, 2'd3);
        push_seg("off_on_tick", 184, 195, 0, 163);
        write_at(182, 2'd0);

        for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
